guess_game_ctrl: RTL
====================

# guess_game_ctrl

Game controller that sits directly downstream of the three button debouncers (up, down, enter) in the random-number guessing game. It converts their pulse outputs into single-cycle press events and draws a target from a free-running LFSR. It runs the guess/compare state machine and drives the hint, win/lose and attempt-count outputs toward the display logic. Debouncer outputs stay high for a full slow-clock period, so this block performs its own rising-edge detection in the `in_clk` domain.

## Interface
- `WIDTH`, 4: guess/target width in bits (range 0..2^WIDTH-1).
- `MAX_TRIES`, 7: attempts allowed before loss, 1..15.
- `LFSR_SEED`, 8'hA5: LFSR reset value, must be nonzero.

- `in_clk`  in  1  system clock; only clock in the block.
- `reset`  in  1  synchronous, active-high reset.
- `btn_up`  in  1  debounced up pulse (multi-cycle level).
- `btn_down`  in  1  debounced down pulse.
- `btn_enter`  in  1  debounced enter pulse.
- `guess`  out  WIDTH  current guess value.
- `tries`  out  4  completed attempts in the current round.
- `hint_hi`  out  1  last guess was above target.
- `hint_lo`  out  1  last guess was below target.
- `win`  out  1  round won.
- `lose`  out  1  round lost.
- `target`  out  WIDTH  captured target; present only with `GAME_CHEAT_EN`.

## Operation
- Edge detect: `press_x = btn_x & ~btn_x_q`, where `btn_x_q` is the registered input. All `btn_x_q` reset to 1, so a button held through reset produces no press.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. Loads `LFSR_SEED` on reset and advances every cycle in all states.
- States: IDLE, PLAY, CHECK, WIN, LOSE. Reset state is IDLE.
- IDLE, on `press_enter`:
  - capture `target <= lfsr[WIDTH-1:0]`;
  - clear `guess`, `tries`, `hint_hi` and `hint_lo`;
  - go to PLAY.
- IDLE ignores up/down.
- PLAY:
  - `press_up` adds 1 to `guess`, wrapping from max to 0.
  - `press_down` subtracts 1, wrapping from 0 to max.
  - Up and down pressed in the same cycle: no change.
  - `press_enter` goes to CHECK and takes priority over up/down in the same cycle; `guess` stays unchanged.
- CHECK lasts exactly one cycle:
  - `tries <= tries+1`.
  - If `guess == target`: go to WIN and clear both hints.
  - Else if `tries+1 == MAX_TRIES`: go to LOSE, with the hints set for this final guess.
  - Else: set `hint_hi = guess > target` and `hint_lo = guess < target`, then go to PLAY.
  - Presses arriving during CHECK are dropped.
- WIN/LOSE:
  - `win` or `lose` holds high; `guess`, `tries` and the hints are frozen.
  - Up/down are ignored.
  - `press_enter` goes to IDLE.
- Invariants: `hint_hi` and `hint_lo` are never both 1; `win` and `lose` are never both 1.
- Reset mid-round: all state returns to reset values on the next edge; the round is lost.

## Timing
- Reset values: `guess=0`, `tries=0`, `hint_hi=0`, `hint_lo=0`, `win=0`, `lose=0`, `target=0`.
- All outputs are registered.
- Latency from a button input rising to its press effect: 2 cycles (1 cycle for input registration, 1 for the state update).
- Enter in PLAY to result on outputs (hints, `tries`, `win`/`lose`): 3 cycles.
- A held button generates exactly one press per rising edge, regardless of how long it stays high.

## Configuration
- Macro: `GAME_CHEAT_EN`.
- Defined: the `target` output port exists and drives the captured target register.
- Undefined: the port is omitted. Target storage and behaviour are otherwise identical.

## Structure
- Shared package `game_pkg` holds:
  - the state encoding constants (IDLE=0, PLAY=1, CHECK=2, WIN=3, LOSE=4, 3 bits);
  - the LFSR tap mask;
  - the default seed.
- One sub-module, `lfsr8`, with ports `in_clk`, `reset` and `q[7:0]`, and parameter `SEED`.
- Edge detection and the FSM are inline in `guess_game_ctrl`.

## Test plan
All scenarios are built with `GAME_CHEAT_EN` so the bench can read `target`.
- Enter held for 50 cycles in IDLE: exactly one transition to PLAY; `tries=0`; `target` equals `lfsr[3:0]` sampled at the press.
- Target=9, guess=0: press up 12 times then enter → `guess=12`, `hint_hi=1`, `tries=1`. Press down 3 times then enter → `guess=9`, `win=1`, `tries=2`.
- Wrap: from guess 0, down → 15; then up → 0.
- Loss: `MAX_TRIES=3`, target≠0, enter 3 times with guess 0 → `lose=1`, `tries=3`, `hint_lo=1`. A further enter → IDLE with `lose=0`.
- Simultaneous: up and down rising in the same cycle → `guess` unchanged. Enter and up in the same cycle while in PLAY → CHECK entered, `guess` unchanged.
- Reset asserted while in CHECK, with enter held high throughout: all outputs go to 0, the state is IDLE, and no press is registered after reset deasserts until enter falls and rises again.

Source files
------------

// File: rtl/game_pkg.sv
// ----------------------------------------------------------------------------
// game_pkg
// Shared definitions for the guessing-game controller:
//   - state_t     : FSM encoding (IDLE=0, PLAY=1, CHECK=2, WIN=3, LOSE=4)
//   - LFSR_TAP_MASK : taps 8,6,5,4 of the 8-bit Fibonacci LFSR (bits 7,5,4,3)
//   - LFSR_SEED_DEF : default nonzero LFSR reset value
//   - lfsr_fb()   : feedback bit for a given LFSR state
// ----------------------------------------------------------------------------
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_PLAY  = 3'd1,
      ST_CHECK = 3'd2,
      ST_WIN   = 3'd3,
      ST_LOSE  = 3'd4
   } state_t;

   localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;
   localparam logic [7:0] LFSR_SEED_DEF = 8'hA5;

   function automatic logic lfsr_fb(input logic [7:0] i_q);
      return ^(i_q & LFSR_TAP_MASK);
   endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr8.sv
// ----------------------------------------------------------------------------
// lfsr8
// Free-running 8-bit Fibonacci LFSR used as the target source. Shifts left,
// feedback enters at bit 0. Advances every cycle out of reset.
// Ports:
//   in_clk  in  1  clock
//   reset   in  1  synchronous active-high reset, loads SEED
//   q       out 8  current LFSR state
// SEED must be nonzero; an all-zero state is a lock-up state.
// ----------------------------------------------------------------------------
module lfsr8
   import game_pkg::*;
#(
   parameter logic [7:0] SEED = LFSR_SEED_DEF
) (
   input  logic       in_clk,
   input  logic       reset,
   output logic [7:0] q
);

   logic [7:0] r_q;

   always_ff @(posedge in_clk) begin
      if (reset) r_q <= SEED;
      else       r_q <= {r_q[6:0], lfsr_fb(r_q)};
   end

   assign q = r_q;

endmodule

// File: rtl/guess_game_ctrl.sv
// ----------------------------------------------------------------------------
// guess_game_ctrl
// Random-number guessing game controller. Converts debounced button levels
// into single-cycle presses, draws a target from an LFSR and runs the
// guess/compare FSM driving hints, win/lose and attempt count.
// Ports:
//   in_clk     in  1      system clock
//   reset      in  1      synchronous active-high reset
//   btn_up     in  1      debounced up level
//   btn_down   in  1      debounced down level
//   btn_enter  in  1      debounced enter level
//   guess      out WIDTH  current guess
//   tries      out 4      completed attempts this round
//   hint_hi    out 1      last guess above target
//   hint_lo    out 1      last guess below target
//   win        out 1      round won
//   lose       out 1      round lost
//   target     out WIDTH  captured target (only with GAME_CHEAT_EN defined)
// Configuration macro: GAME_CHEAT_EN exposes the target register as a port.
// ----------------------------------------------------------------------------
module guess_game_ctrl
   import game_pkg::*;
#(
   parameter int         WIDTH     = 4,
   parameter int         MAX_TRIES = 7,
   parameter logic [7:0] LFSR_SEED = LFSR_SEED_DEF
) (
   input  logic             in_clk,
   input  logic             reset,
   input  logic             btn_up,
   input  logic             btn_down,
   input  logic             btn_enter,
   output logic [WIDTH-1:0] guess,
   output logic [3:0]       tries,
   output logic             hint_hi,
   output logic             hint_lo,
   output logic             win,
   output logic             lose
`ifdef GAME_CHEAT_EN
   ,
   output logic [WIDTH-1:0] target
`endif
);

   // ---------------------------------------------------------------------
   // Button capture and edge detect. Both stages reset to 1 so a button
   // held through reset looks like a steady level, not a fresh press.
   // ---------------------------------------------------------------------
   logic [2:0] r_btn_s;   // {enter, down, up} registered inputs
   logic [2:0] r_btn_q;   // one cycle older copy
   logic [2:0] w_press;

   always_ff @(posedge in_clk) begin
      if (reset) begin
         r_btn_s <= 3'b111;
         r_btn_q <= 3'b111;
      end else begin
         r_btn_s <= {btn_enter, btn_down, btn_up};
         r_btn_q <= r_btn_s;
      end
   end

   assign w_press = r_btn_s & ~r_btn_q;

   logic w_press_up, w_press_down, w_press_enter;
   assign w_press_up    = w_press[0];
   assign w_press_down  = w_press[1];
   assign w_press_enter = w_press[2];

   // ---------------------------------------------------------------------
   // Target source
   // ---------------------------------------------------------------------
   logic [7:0] w_lfsr;
   logic       w_unused_lfsr;

   lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .in_clk (in_clk),
      .reset  (reset),
      .q      (w_lfsr)
   );

   // Only the low WIDTH bits become the target.
   assign w_unused_lfsr = ^w_lfsr;

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   state_t           r_state,   w_state_nxt;
   logic [WIDTH-1:0] r_guess,   w_guess_nxt;
   logic [WIDTH-1:0] r_target,  w_target_nxt;
   logic [3:0]       r_tries,   w_tries_nxt;
   logic             r_hint_hi, w_hint_hi_nxt;
   logic             r_hint_lo, w_hint_lo_nxt;
   logic             r_win,     w_win_nxt;
   logic             r_lose,    w_lose_nxt;
   logic [3:0]       w_tries_inc;

   assign w_tries_inc = r_tries + 4'd1;

   always_ff @(posedge in_clk) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_guess   <= '0;
         r_target  <= '0;
         r_tries   <= '0;
         r_hint_hi <= 1'b0;
         r_hint_lo <= 1'b0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_guess   <= w_guess_nxt;
         r_target  <= w_target_nxt;
         r_tries   <= w_tries_nxt;
         r_hint_hi <= w_hint_hi_nxt;
         r_hint_lo <= w_hint_lo_nxt;
         r_win     <= w_win_nxt;
         r_lose    <= w_lose_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_guess_nxt   = r_guess;
      w_target_nxt  = r_target;
      w_tries_nxt   = r_tries;
      w_hint_hi_nxt = r_hint_hi;
      w_hint_lo_nxt = r_hint_lo;

      case (r_state)
         ST_IDLE: begin
            if (w_press_enter) begin
               w_target_nxt  = w_lfsr[WIDTH-1:0];
               w_guess_nxt   = '0;
               w_tries_nxt   = '0;
               w_hint_hi_nxt = 1'b0;
               w_hint_lo_nxt = 1'b0;
               w_state_nxt   = ST_PLAY;
            end
         end

         ST_PLAY: begin
            // Enter wins over up/down; up+down together cancel.
            if (w_press_enter)
               w_state_nxt = ST_CHECK;
            else if (w_press_up && !w_press_down)
               w_guess_nxt = r_guess + WIDTH'(1);
            else if (w_press_down && !w_press_up)
               w_guess_nxt = r_guess - WIDTH'(1);
         end

         ST_CHECK: begin
            w_tries_nxt = w_tries_inc;
            if (r_guess == r_target) begin
               w_hint_hi_nxt = 1'b0;
               w_hint_lo_nxt = 1'b0;
               w_state_nxt   = ST_WIN;
            end else begin
               w_hint_hi_nxt = (r_guess > r_target);
               w_hint_lo_nxt = (r_guess < r_target);
               w_state_nxt   = (w_tries_inc == 4'(MAX_TRIES)) ? ST_LOSE : ST_PLAY;
            end
         end

         ST_WIN, ST_LOSE: begin
            if (w_press_enter) w_state_nxt = ST_IDLE;
         end

         default: w_state_nxt = ST_IDLE;
      endcase

      // Flags are registered copies of the next state so they line up with it.
      w_win_nxt  = (w_state_nxt == ST_WIN);
      w_lose_nxt = (w_state_nxt == ST_LOSE);
   end

   assign guess   = r_guess;
   assign tries   = r_tries;
   assign hint_hi = r_hint_hi;
   assign hint_lo = r_hint_lo;
   assign win     = r_win;
   assign lose    = r_lose;

`ifdef GAME_CHEAT_EN
   assign target = r_target;
`endif

endmodule
